// File: rtl/io_port_bridge_if.sv
// Peripheral-side bus of io_port_bridge: the write request handshake
// (valid/ready, address, data) plus the input-register update strobe.
// master = bridge side, slave = peripheral side.
interface io_port_bridge_if #(
  parameter int N_IN = 4
) ();
  localparam int PW = $clog2(N_IN);

  logic          io_valid;
  logic          io_ready;
  logic [15:0]   io_addr;
  logic [15:0]   io_wdata;
  logic          io_rd_valid;
  logic [PW-1:0] io_rd_port;
  logic [15:0]   io_rd_data;

  modport master (
    output io_valid, io_addr, io_wdata,
    input  io_ready, io_rd_valid, io_rd_port, io_rd_data
  );

  modport slave (
    input  io_valid, io_addr, io_wdata,
    output io_ready, io_rd_valid, io_rd_port, io_rd_data
  );
endinterface

// File: rtl/io_port_bridge.sv
// io_port_bridge: queues single-cycle CPU OUT writes into a small FIFO and
// drains them to peripherals over a valid/ready handshake; holds a bank of
// peripheral-updated input registers read back on cpu_in.
// Capacity is DEPTH: DEPTH-1 FIFO slots plus the registered output stage.
// Optional: define IO_TIMEOUT_EN to abandon requests stalled for
// TIMEOUT_CYCLES cycles (sets the sticky timeout flag).
module io_port_bridge #(
  parameter int DEPTH          = 4,
  parameter int N_IN           = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            cpu_addr,
  input  logic [15:0]            cpu_data,
  input  logic                   cpu_wr,
  output logic [15:0]            cpu_in,
  io_port_bridge_if.master       io,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   timeout
);
  localparam int FSIZE = DEPTH - 1;
  localparam int PTR_W = (FSIZE > 1) ? $clog2(FSIZE) : 1;
  localparam int CNT_W = $clog2(DEPTH);
  localparam int PW    = $clog2(N_IN);

  typedef enum logic {IDLE, SEND} state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } entry_t;

  state_t           state;
  entry_t           mem [FSIZE];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic [15:0]      in_regs [N_IN];

  logic fifo_empty, full, xfer_done, pop, push, tmo_hit;

  // FIFO size need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FSIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_count = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, (state == SEND)};
  assign full       = (fifo_count == (CNT_W + 1)'(DEPTH));
  // A request finishes when accepted, or when abandoned by the timeout.
  assign xfer_done  = (state == SEND) && (io.io_ready || tmo_hit);
  assign pop        = !fifo_empty && ((state == IDLE) || xfer_done);
  // Popping frees the output stage's slot on the same edge, so a full bridge
  // still accepts a write while a transfer completes.
  assign push       = cpu_wr && (!full || pop);

`ifdef IO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == SEND) && !io.io_ready &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Stall counter: counts stalled SEND cycles, cleared on entry and on each completed transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else if (state == SEND && !xfer_done) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
      if (tmo_hit) timeout <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  // FIFO storage write port; the payload needs no reset because occupancy gates every read.
  // NOTE: data arrays without reset map to plain RAM/flop arrays; only control state is reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: cpu_addr, data: cpu_data};
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  // NOTE: every sequential block uses non-blocking assignments so all flops
  // update from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      if (cpu_wr && !push) overflow <= 1'b1;
    end
  end

  // Drain FSM with a registered output stage holding the presented request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      io.io_valid <= 1'b0;
      io.io_addr  <= '0;
      io.io_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            io.io_addr  <= mem[rd_ptr].addr;
            io.io_wdata <= mem[rd_ptr].data;
            io.io_valid <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          if (xfer_done) begin
            if (pop) begin
              io.io_addr  <= mem[rd_ptr].addr;
              io.io_wdata <= mem[rd_ptr].data;
            end else begin
              io.io_valid <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Input registers: peripheral updates and a one-cycle registered CPU read (no bypass).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) in_regs[i] <= '0;
      cpu_in <= '0;
    end else begin
      if (io.io_rd_valid) in_regs[io.io_rd_port] <= io.io_rd_data;
      if (cpu_addr < 16'(N_IN)) cpu_in <= in_regs[cpu_addr[PW-1:0]];
      else                      cpu_in <= '0;
    end
  end
endmodule

// File: doc/io_port_bridge.md
Name: io_port_bridge

Overview:
- Downstream of the CPU's OUT/IN path. Captures the CPU port-write strobe (address = bx, data = dx, one-cycle r/w flag) into a small write FIFO.
- Drains the FIFO to the peripheral bus with a valid/ready handshake.
- Keeps a bank of input-port registers that peripherals update. Returns the selected register to the CPU `in` input.
- Decouples single-cycle CPU OUT instructions from slow peripherals.

Parameters:
- DEPTH, 4, write FIFO entries; power of 2, minimum 2.
- N_IN, 4, number of input-port registers; power of 2, minimum 2.
- TIMEOUT_CYCLES, 255, handshake timeout limit; used only when IO_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  16  port address (CPU bx).
- cpu_data  in  16  write data (CPU dx).
- cpu_wr  in  1  write strobe (CPU flag); one-cycle pulse per OUT instruction.
- cpu_in  out  16  registered input-port value (to CPU in).
- io_valid  out  1  write request to peripherals.
- io_ready  in  1  peripheral accepts the request.
- io_addr  out  16  request address.
- io_wdata  out  16  request data.
- io_rd_valid  in  1  peripheral update strobe for an input register.
- io_rd_port  in  log2(N_IN)  input register index.
- io_rd_data  in  16  input register value.
- fifo_count  out  log2(DEPTH)+1  entries held, including the entry in the output stage.
- overflow  out  1  sticky flag: a write was dropped.
- timeout  out  1  sticky flag: a request was abandoned (feature only).

Behaviour:
- Reset: synchronous, active-high, clock clk. While reset is high:
  - io_valid, io_addr, io_wdata, cpu_in, fifo_count, overflow, timeout all drive 0.
  - FIFO pointers clear and all input registers clear to 0.
  - Reset mid-handshake abandons the pending request. io_valid is 0 on the cycle after the reset edge.
- Write capture:
  - cpu_wr high at edge N pushes {cpu_addr, cpu_data}.
  - The push is accepted if the occupancy is below DEPTH, or if a pop occurs on the same edge.
  - Otherwise the write is dropped and overflow is set; it stays set until reset.
  - cpu_wr is level-sampled every edge. The bridge does no edge detection.
- Drain FSM:
  - IDLE: io_valid = 0. If the FIFO is non-empty at an edge, load the head into io_addr/io_wdata, pop it, and go to SEND.
  - SEND: io_valid = 1. io_addr/io_wdata are held stable until io_ready is sampled high.
  - On io_ready high in SEND: if the FIFO is non-empty, load and pop the next entry and stay in SEND. Otherwise go to IDLE.
  - Throughput: one transfer per cycle while io_ready is held high.
- Latency: cpu_wr at edge N with an empty bridge gives io_valid high after edge N+1.
- Ordering: strictly FIFO; no reordering and no merging of same-address writes.
- Occupancy: fifo_count = FIFO entries + (state == SEND). The FIFO proper is DEPTH-1 entries plus the output stage, so total capacity is DEPTH. Pointers wrap modulo the FIFO size.
- Input registers:
  - io_rd_valid at an edge writes io_rd_data into register io_rd_port.
  - cpu_in is updated every edge with register[cpu_addr[log2(N_IN)-1:0]] when cpu_addr < N_IN, else 0. Read latency is 1 cycle.
  - No bypass: if the same register is written on the same edge, cpu_in shows the old value for that cycle.
- Simultaneous cpu_wr and io_rd_valid are independent; both take effect.

Optional Feature:
- Macro IO_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to SEND and on each accepted transfer, and increments each cycle in SEND with io_ready low.
  - When it reaches TIMEOUT_CYCLES, the current request is dropped and timeout is set (sticky until reset).
  - The FSM then proceeds exactly as if io_ready had been sampled high.
- Not defined: the bridge waits indefinitely, timeout is tied to 0, and there is no counter logic.

Test Plan:
- Single write, io_ready tied high: cpu_wr pulse with addr=0x0001, data=0x0001 -> io_valid high for exactly 1 cycle, appearing 2 edges after the strobe, carrying 0x0001/0x0001; fifo_count returns to 0.
- Back-pressure and overflow: io_ready=0, 5 consecutive writes (data 1..5), DEPTH=4 -> fifo_count=4 and overflow=1. Then io_ready=1 -> data 1,2,3,4 emerge in order on 4 consecutive cycles; 5 never appears.
- Full with simultaneous pop: FIFO full, io_ready=1 and cpu_wr on the same edge -> push accepted, overflow stays 0, fifo_count stays 4.
- Input registers: io_rd_valid, port 2, data 0xBEEF -> cpu_addr=2 gives cpu_in=0xBEEF one cycle later; cpu_addr=7 gives 0x0000; a same-cycle write/read of port 2 returns the old value first.
- Reset mid-SEND: io_valid high with io_ready=0, assert reset for 1 cycle -> io_valid=0, fifo_count=0, overflow=0, cpu_in=0; the old request never completes.
- IO_TIMEOUT_EN with TIMEOUT_CYCLES=8: two queued writes, io_ready=0 -> after 8 stalled cycles the first request is dropped, timeout=1, and the second request is presented.
